// File: rtl/instruction_decoder.sv
// TTM4 control-unit decoder: turns opcode, register selectors and flags into
// registered, mostly active-low strobes for the register file, ALU, stack and PC.
module instruction_decoder (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Z_FLAG,
    input  logic       C_FLAG,
    input  logic [4:0] OP,
    input  logic [2:0] SR,
    input  logic [2:0] LR,
    output logic       nA_OUT,
    output logic       nB_OUT,
    output logic       nIRU_OUT,
    output logic       nIRD_OUT,
    output logic       nJRU_OUT,
    output logic       nJRD_OUT,
    output logic       nA_ST,
    output logic       nB_ST,
    output logic       nORU_ST,
    output logic       nORD_ST,
    output logic       nJRU_ST,
    output logic       nJRD_ST,
    output logic [1:0] SEL,
    output logic       nFA_EN,
    output logic       nAND_EN,
    output logic       nOR_EN,
    output logic       nXOR_EN,
    output logic       nSK_EN,
    output logic       SP_D_nU,
    output logic       PC_nLD,
    output logic       SPC
);

    localparam logic [4:0] OP_MOV = 5'b00001;
    localparam logic [4:0] OP_POP = 5'b01000;
    localparam logic [4:0] OP_PSH = 5'b01001;
    localparam logic [4:0] OP_JNC = 5'b01010;
    localparam logic [4:0] OP_JC  = 5'b01011;
    localparam logic [4:0] OP_JMP = 5'b01100;
    localparam logic [4:0] OP_JNZ = 5'b01110;
    localparam logic [4:0] OP_JZ  = 5'b01111;
    localparam logic [4:0] OP_AND = 5'b10000;
    localparam logic [4:0] OP_XOR = 5'b10001;
    localparam logic [4:0] OP_OR  = 5'b10010;
    localparam logic [4:0] OP_ADD = 5'b10100;
    localparam logic [4:0] OP_SUB = 5'b10110;
    localparam logic [4:0] OP_CMP = 5'b10111;

    localparam logic [1:0] SEL_BUS   = 2'b00;
    localparam logic [1:0] SEL_LOGIC = 2'b01;
    localparam logic [1:0] SEL_ADDER = 2'b10;
    localparam logic [1:0] SEL_STACK = 2'b11;

    // nOut/nSt bit index equals the SR/LR code that selects it.
    typedef struct packed {
        logic [5:0] nOut;
        logic [5:0] nSt;
        logic [1:0] sel;
        logic       nFaEn;
        logic       nAndEn;
        logic       nOrEn;
        logic       nXorEn;
        logic       nSkEn;
        logic       spDnU;
        logic       pcNld;
        logic       spc;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{
        nOut:   6'b111111,
        nSt:    6'b111111,
        sel:    SEL_BUS,
        nFaEn:  1'b1,
        nAndEn: 1'b1,
        nOrEn:  1'b1,
        nXorEn: 1'b1,
        nSkEn:  1'b1,
        spDnU:  1'b0,
        pcNld:  1'b1,
        spc:    1'b0
    };

    // Codes 110/111 (and unknown codes in simulation) fall to the default: nothing selected.
    function automatic logic [5:0] selectLowHot(input logic [2:0] code);
        case (code)
            3'b000:  return 6'b111110;
            3'b001:  return 6'b111101;
            3'b010:  return 6'b111011;
            3'b011:  return 6'b110111;
            3'b100:  return 6'b101111;
            3'b101:  return 6'b011111;
            default: return 6'b111111;
        endcase
    endfunction

    function automatic logic jumpTaken(input logic [4:0] opcode, input logic zf, input logic cf);
        case (opcode)
            OP_JMP:  return 1'b1;
            OP_JNC:  return ~cf;
            OP_JC:   return cf;
            OP_JNZ:  return ~zf;
            OP_JZ:   return zf;
            default: return 1'b0;
        endcase
    endfunction

    ctrl_t ctrl_p0;
    ctrl_t ctrl_p1;

    // Stage 0: combinational decode of the current instruction
    always_comb begin
        ctrl_p0 = CTRL_IDLE;
        case (OP)
            OP_MOV: begin
                ctrl_p0.nOut = selectLowHot(SR);
                ctrl_p0.nSt  = selectLowHot(LR);
                ctrl_p0.sel  = SEL_BUS;
            end
            OP_AND: begin
                ctrl_p0.nOut   = selectLowHot(SR);
                ctrl_p0.nSt    = selectLowHot(LR);
                ctrl_p0.sel    = SEL_LOGIC;
                ctrl_p0.nAndEn = 1'b0;
            end
            OP_OR: begin
                ctrl_p0.nOut  = selectLowHot(SR);
                ctrl_p0.nSt   = selectLowHot(LR);
                ctrl_p0.sel   = SEL_LOGIC;
                ctrl_p0.nOrEn = 1'b0;
            end
            OP_XOR: begin
                ctrl_p0.nOut   = selectLowHot(SR);
                ctrl_p0.nSt    = selectLowHot(LR);
                ctrl_p0.sel    = SEL_LOGIC;
                ctrl_p0.nXorEn = 1'b0;
            end
            OP_ADD: begin
                ctrl_p0.nOut  = selectLowHot(SR);
                ctrl_p0.nSt   = selectLowHot(LR);
                ctrl_p0.sel   = SEL_ADDER;
                ctrl_p0.nFaEn = 1'b0;
            end
            OP_SUB: begin
                ctrl_p0.nOut   = selectLowHot(SR);
                ctrl_p0.nSt    = selectLowHot(LR);
                ctrl_p0.sel    = SEL_ADDER;
                ctrl_p0.nFaEn  = 1'b0;
                ctrl_p0.nXorEn = 1'b0;
            end
            OP_CMP: begin
                // Subtract for the flags only; the result is never stored.
                ctrl_p0.nOut   = selectLowHot(SR);
                ctrl_p0.sel    = SEL_ADDER;
                ctrl_p0.nFaEn  = 1'b0;
                ctrl_p0.nXorEn = 1'b0;
            end
            OP_JMP, OP_JNC, OP_JC, OP_JNZ, OP_JZ: begin
                if (jumpTaken(OP, Z_FLAG, C_FLAG)) begin
                    ctrl_p0.pcNld = 1'b0;
                    ctrl_p0.spc   = 1'b0;
                end
            end
            OP_PSH: begin
                ctrl_p0.nSkEn = 1'b0;
                ctrl_p0.spDnU = 1'b0;
                ctrl_p0.sel   = SEL_STACK;
            end
            OP_POP: begin
                // Return: pop the stack and reload PC from the popped value.
                ctrl_p0.nSkEn = 1'b0;
                ctrl_p0.spDnU = 1'b1;
                ctrl_p0.sel   = SEL_STACK;
                ctrl_p0.pcNld = 1'b0;
                ctrl_p0.spc   = 1'b1;
            end
            default: ctrl_p0 = CTRL_IDLE;
        endcase
    end

    // Stage 1: registered control word, reset cancels any in-flight strobes
    always_ff @(posedge CLK) begin
        if (RST) begin
            ctrl_p1 <= CTRL_IDLE;
        end else begin
            ctrl_p1 <= ctrl_p0;
        end
    end

    assign nA_OUT   = ctrl_p1.nOut[0];
    assign nB_OUT   = ctrl_p1.nOut[1];
    assign nIRU_OUT = ctrl_p1.nOut[2];
    assign nIRD_OUT = ctrl_p1.nOut[3];
    assign nJRU_OUT = ctrl_p1.nOut[4];
    assign nJRD_OUT = ctrl_p1.nOut[5];
    assign nA_ST    = ctrl_p1.nSt[0];
    assign nB_ST    = ctrl_p1.nSt[1];
    assign nORU_ST  = ctrl_p1.nSt[2];
    assign nORD_ST  = ctrl_p1.nSt[3];
    assign nJRU_ST  = ctrl_p1.nSt[4];
    assign nJRD_ST  = ctrl_p1.nSt[5];
    assign SEL      = ctrl_p1.sel;
    assign nFA_EN   = ctrl_p1.nFaEn;
    assign nAND_EN  = ctrl_p1.nAndEn;
    assign nOR_EN   = ctrl_p1.nOrEn;
    assign nXOR_EN  = ctrl_p1.nXorEn;
    assign nSK_EN   = ctrl_p1.nSkEn;
    assign SP_D_nU  = ctrl_p1.spDnU;
    assign PC_nLD   = ctrl_p1.pcNld;
    assign SPC      = ctrl_p1.spc;

endmodule

// File: tb/tb_instruction_decoder.sv
// Directed bench for instruction_decoder: vector table plus reset, hold,
// latency and undefined-selector sequences.
module tb_instruction_decoder;

    logic tb_CLK = 1'b0;
    always #5 tb_CLK = ~tb_CLK;

    logic       rst;
    logic       zFlag;
    logic       cFlag;
    logic [4:0] op;
    logic [2:0] sr;
    logic [2:0] lr;

    logic nA_OUT, nB_OUT, nIRU_OUT, nIRD_OUT, nJRU_OUT, nJRD_OUT;
    logic nA_ST, nB_ST, nORU_ST, nORD_ST, nJRU_ST, nJRD_ST;
    logic [1:0] sel;
    logic nFA_EN, nAND_EN, nOR_EN, nXOR_EN, nSK_EN, SP_D_nU, PC_nLD, SPC;

    instruction_decoder dut (
        .CLK(tb_CLK), .RST(rst), .Z_FLAG(zFlag), .C_FLAG(cFlag),
        .OP(op), .SR(sr), .LR(lr),
        .nA_OUT(nA_OUT), .nB_OUT(nB_OUT), .nIRU_OUT(nIRU_OUT),
        .nIRD_OUT(nIRD_OUT), .nJRU_OUT(nJRU_OUT), .nJRD_OUT(nJRD_OUT),
        .nA_ST(nA_ST), .nB_ST(nB_ST), .nORU_ST(nORU_ST),
        .nORD_ST(nORD_ST), .nJRU_ST(nJRU_ST), .nJRD_ST(nJRD_ST),
        .SEL(sel), .nFA_EN(nFA_EN), .nAND_EN(nAND_EN), .nOR_EN(nOR_EN),
        .nXOR_EN(nXOR_EN), .nSK_EN(nSK_EN), .SP_D_nU(SP_D_nU),
        .PC_nLD(PC_nLD), .SPC(SPC)
    );

    // nOut = {JRD,JRU,IRD,IRU,B,A}, nSt = {JRD,JRU,ORD,ORU,B,A}
    typedef struct packed {
        logic [5:0] nOut;
        logic [5:0] nSt;
        logic [1:0] sel;
        logic fa, an, orr, xr, sk, spd, pc, spc;
    } outs_t;

    typedef struct {
        string      name;
        logic [4:0] op;
        logic [2:0] sr;
        logic [2:0] lr;
        logic       z;
        logic       c;
        outs_t      exp;
    } vec_t;

    outs_t actual;
    assign actual = {nJRD_OUT, nJRU_OUT, nIRD_OUT, nIRU_OUT, nB_OUT, nA_OUT,
                     nJRD_ST, nJRU_ST, nORD_ST, nORU_ST, nB_ST, nA_ST,
                     sel, nFA_EN, nAND_EN, nOR_EN, nXOR_EN, nSK_EN, SP_D_nU, PC_nLD, SPC};

    localparam outs_t IDLE = {6'b111111, 6'b111111, 2'b00,
                              1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    int nChecks = 0;
    int nFails  = 0;
    vec_t vecs[$];

    function automatic outs_t mk(logic [5:0] o, logic [5:0] s, logic [1:0] sl,
                                 logic fa, logic an, logic orr, logic xr,
                                 logic sk, logic spd, logic pc, logic spc);
        return {o, s, sl, fa, an, orr, xr, sk, spd, pc, spc};
    endfunction

    task automatic check(input string name, input outs_t exp);
        nChecks++;
        if (actual !== exp) begin
            nFails++;
            $display("FAIL %s: got %b required %b", name, actual, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [4:0] o, input logic [2:0] s,
                         input logic [2:0] l, input logic z, input logic c);
        @(negedge tb_CLK);
        rst = r; op = o; sr = s; lr = l; zFlag = z; cFlag = c;
    endtask

    task automatic edgeThenSample();
        @(posedge tb_CLK);
        #1;
    endtask

    function automatic void addVec(string n, logic [4:0] o, logic [2:0] s, logic [2:0] l,
                                   logic z, logic c, outs_t e);
        vec_t v;
        v.name = n; v.op = o; v.sr = s; v.lr = l; v.z = z; v.c = c; v.exp = e;
        vecs.push_back(v);
    endfunction

    outs_t movExp;
    outs_t pshExp;
    outs_t popExp;
    logic [5:0] xOut;

    initial begin
        rst = 1'b1; op = 5'b01100; sr = 3'b000; lr = 3'b000; zFlag = 1'b0; cFlag = 1'b0;

        // Register-class vectors
        addVec("mov_B_ORU", 5'b00001, 3'b001, 3'b010, 0, 0,
               mk(6'b111101, 6'b111011, 2'b00, 1,1,1,1,1,0,1,0));
        addVec("mov_A_JRD", 5'b00001, 3'b000, 3'b101, 0, 0,
               mk(6'b111110, 6'b011111, 2'b00, 1,1,1,1,1,0,1,0));
        addVec("mov_JRU_A", 5'b00001, 3'b100, 3'b000, 1, 1,
               mk(6'b101111, 6'b111110, 2'b00, 1,1,1,1,1,0,1,0));
        addVec("mov_JRD_JRU", 5'b00001, 3'b101, 3'b100, 0, 0,
               mk(6'b011111, 6'b101111, 2'b00, 1,1,1,1,1,0,1,0));
        addVec("mov_IRU_B", 5'b00001, 3'b010, 3'b001, 0, 0,
               mk(6'b111011, 6'b111101, 2'b00, 1,1,1,1,1,0,1,0));
        addVec("and", 5'b10000, 3'b011, 3'b011, 0, 0,
               mk(6'b110111, 6'b110111, 2'b01, 1,0,1,1,1,0,1,0));
        addVec("or", 5'b10010, 3'b011, 3'b011, 0, 0,
               mk(6'b110111, 6'b110111, 2'b01, 1,1,0,1,1,0,1,0));
        addVec("xor", 5'b10001, 3'b011, 3'b011, 0, 0,
               mk(6'b110111, 6'b110111, 2'b01, 1,1,1,0,1,0,1,0));
        addVec("add", 5'b10100, 3'b011, 3'b011, 0, 0,
               mk(6'b110111, 6'b110111, 2'b10, 0,1,1,1,1,0,1,0));
        addVec("sub", 5'b10110, 3'b011, 3'b011, 0, 0,
               mk(6'b110111, 6'b110111, 2'b10, 0,1,1,0,1,0,1,0));
        addVec("cmp", 5'b10111, 3'b011, 3'b011, 0, 0,
               mk(6'b110111, 6'b111111, 2'b10, 0,1,1,0,1,0,1,0));
        addVec("psh", 5'b01001, 3'b000, 3'b000, 0, 0,
               mk(6'b111111, 6'b111111, 2'b11, 1,1,1,1,0,0,1,0));
        addVec("pop", 5'b01000, 3'b001, 3'b001, 1, 1,
               mk(6'b111111, 6'b111111, 2'b11, 1,1,1,1,0,1,0,1));
        addVec("nop00000", 5'b00000, 3'b000, 3'b000, 1, 1, IDLE);
        addVec("nop00010", 5'b00010, 3'b001, 3'b010, 0, 0, IDLE);
        addVec("nop11111", 5'b11111, 3'b011, 3'b011, 1, 0, IDLE);
        addVec("mov_sr111_lr110", 5'b00001, 3'b111, 3'b110, 0, 0, IDLE);

        // Jumps under all flag combinations; SR/LR set to show they are ignored
        for (int zc = 0; zc < 4; zc++) begin
            logic z, c;
            z = (zc >= 2);
            c = (zc % 2 == 1);
            addVec($sformatf("jmp_z%0d_c%0d", z, c), 5'b01100, 3'b000, 3'b001, z, c,
                   mk(6'b111111, 6'b111111, 2'b00, 1,1,1,1,1,0, 1'b0, 0));
            addVec($sformatf("jnc_z%0d_c%0d", z, c), 5'b01010, 3'b000, 3'b001, z, c,
                   mk(6'b111111, 6'b111111, 2'b00, 1,1,1,1,1,0, c, 0));
            addVec($sformatf("jc_z%0d_c%0d", z, c), 5'b01011, 3'b000, 3'b001, z, c,
                   mk(6'b111111, 6'b111111, 2'b00, 1,1,1,1,1,0, ~c, 0));
            addVec($sformatf("jnz_z%0d_c%0d", z, c), 5'b01110, 3'b000, 3'b001, z, c,
                   mk(6'b111111, 6'b111111, 2'b00, 1,1,1,1,1,0, z, 0));
            addVec($sformatf("jz_z%0d_c%0d", z, c), 5'b01111, 3'b000, 3'b001, z, c,
                   mk(6'b111111, 6'b111111, 2'b00, 1,1,1,1,1,0, ~z, 0));
        end

        // Reset held for two edges with a jmp pending
        drive(1'b1, 5'b01100, 3'b000, 3'b000, 0, 0);
        edgeThenSample();
        check("reset_edge1", IDLE);
        edgeThenSample();
        check("reset_edge2", IDLE);
        drive(1'b0, 5'b01100, 3'b000, 3'b000, 0, 0);
        edgeThenSample();
        check("first_decode_jmp", mk(6'b111111, 6'b111111, 2'b00, 1,1,1,1,1,0,0,0));

        foreach (vecs[i]) begin
            drive(1'b0, vecs[i].op, vecs[i].sr, vecs[i].lr, vecs[i].z, vecs[i].c);
            edgeThenSample();
            check(vecs[i].name, vecs[i].exp);
        end

        // Reset on the same edge as a mov cancels it; next edge decodes it
        movExp = mk(6'b111101, 6'b111011, 2'b00, 1,1,1,1,1,0,1,0);
        drive(1'b1, 5'b00001, 3'b001, 3'b010, 0, 0);
        edgeThenSample();
        check("reset_cancels_mov", IDLE);
        drive(1'b0, 5'b00001, 3'b001, 3'b010, 0, 0);
        edgeThenSample();
        check("mov_after_reset", movExp);

        // Held input repeats identical outputs
        pshExp = mk(6'b111111, 6'b111111, 2'b11, 1,1,1,1,0,0,1,0);
        drive(1'b0, 5'b01001, 3'b000, 3'b000, 0, 0);
        for (int k = 0; k < 3; k++) begin
            edgeThenSample();
            check($sformatf("psh_hold%0d", k), pshExp);
        end

        // Input change between edges must not reach the outputs
        popExp = mk(6'b111111, 6'b111111, 2'b11, 1,1,1,1,0,1,0,1);
        drive(1'b0, 5'b01000, 3'b000, 3'b000, 0, 0);
        #1;
        check("no_comb_path", pshExp);
        edgeThenSample();
        check("pop_after_edge", popExp);

        // Partially unknown source selector: nothing driven where the simulator keeps X
        drive(1'b0, 5'b00001, 3'b0x1, 3'b110, 0, 0);
        if ($isunknown(sr)) xOut = 6'b111111;
        else if (sr == 3'b001) xOut = 6'b111101;
        else xOut = 6'b110111;
        edgeThenSample();
        check("mov_sr_0x1", mk(xOut, 6'b111111, 2'b00, 1,1,1,1,1,0,1,0));

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
